// File: rtl/vector_angle_search.sv
// ============================================================================
// Module   : vector_angle_search
// Brief    : First-quadrant (x, y) to integer degrees by binary search over a
//            shared external sin/cos table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vector_angle_search #(
   parameter int W    = 16,
   parameter int ITER = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   output logic [6:0]   rom_angle,
   input  logic [W-1:0] rom_sin,
   input  logic [W-1:0] rom_cos,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [6:0]   out_angle,
   output logic         out_zero
);

   localparam int         CW         = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] C_LAST_CNT = CW'(ITER - 1);
   localparam logic [6:0] C_MAX_ANGLE = 7'd90;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_x;
   logic [W-1:0]    r_y;
   logic [6:0]      r_lo;
   logic [6:0]      r_hi;
   logic [CW-1:0]   r_cnt;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [6:0]      r_out_angle;
   logic            r_out_zero;

   logic [7:0]      w_sum;
   logic [6:0]      w_mid;
   logic [2*W-1:0]  w_ycos;
   logic [2*W-1:0]  w_xsin;
   logic            w_p;
   logic [6:0]      w_lo_nxt;
   logic [6:0]      w_hi_nxt;

   // Upper-median probe keeps lo as the best-known match, so P(lo) stays true.
   assign w_sum  = {1'b0, r_lo} + {1'b0, r_hi} + 8'd1;
   assign w_mid  = w_sum[7:1];
   assign w_ycos = {{W{1'b0}}, r_y} * {{W{1'b0}}, rom_cos};
   assign w_xsin = {{W{1'b0}}, r_x} * {{W{1'b0}}, rom_sin};
   assign w_p    = (w_ycos >= w_xsin);

   always_comb begin
      w_lo_nxt = r_lo;
      w_hi_nxt = r_hi;
      if (r_lo < r_hi) begin
         if (w_p) w_lo_nxt = w_mid;
         else     w_hi_nxt = w_mid - 7'd1;
      end
   end

   assign rom_angle = (r_state == S_SEARCH) ? w_mid : 7'd0;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_angle = r_out_angle;
   assign out_zero  = r_out_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_lo        <= 7'd0;
         r_hi        <= C_MAX_ANGLE;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_angle <= 7'd0;
         r_out_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_x        <= in_x;
                  r_y        <= in_y;
                  r_lo       <= 7'd0;
                  r_hi       <= C_MAX_ANGLE;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  if ((in_x == '0) && (in_y == '0)) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_out_angle <= 7'd0;
                     r_out_zero  <= 1'b1;
                  end else begin
                     r_state <= S_SEARCH;
                  end
               end
            end
            S_SEARCH: begin
               r_lo  <= w_lo_nxt;
               r_hi  <= w_hi_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_LAST_CNT) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_out_angle <= w_lo_nxt;
                  r_out_zero  <= 1'b0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vector_angle_search.sv
// ============================================================================
// Module   : tb_vector_angle_search
// Brief    : Directed self-checking bench for vector_angle_search.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vector_angle_search;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_y;
   logic [6:0]    rom_angle;
   logic [W-1:0]  rom_sin;
   logic [W-1:0]  rom_cos;
   logic          out_valid;
   logic          out_ready;
   logic [6:0]    out_angle;
   logic          out_zero;

   int errors = 0;
   int checks = 0;
   int rom_bad = 0;
   logic [W-1:0] sin_tab [0:90];
   logic [W-1:0] cos_tab [0:90];

   always #5 clk = ~clk;

   vector_angle_search #(.W(W), .ITER(7)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .rom_angle(rom_angle), .rom_sin(rom_sin), .rom_cos(rom_cos),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_angle(out_angle), .out_zero(out_zero)
   );

   always_comb begin
      rom_sin = '0;
      rom_cos = '0;
      if (rom_angle <= 7'd90) begin
         rom_sin = sin_tab[rom_angle];
         rom_cos = cos_tab[rom_angle];
      end
   end

   always @(negedge clk) if (!rst && rom_angle > 7'd90) rom_bad++;

   function automatic logic [W-1:0] q15(input real v);
      return W'($rtoi($floor(32767.0 * v + 0.5 + 1.0e-6)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and waits for its result; the consumer accepts it if out_ready is high.
   task automatic run_request(input logic [W-1:0] x, input logic [W-1:0] y,
                              output logic [6:0] ang, output logic zero, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 40) begin tick(); guard++; end
      in_x = x; in_y = y; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_x = ~x; in_y = ~y;
      lat = 1;
      while (!out_valid && lat < 30) begin tick(); lat++; end
      if (!out_valid) lat = 99;
      ang  = out_angle;
      zero = out_zero;
      if (out_ready && out_valid) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
      tick(); tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_angle !== 7'd0) begin errors++; $display("FAIL reset_out_angle got=%0d exp=0", out_angle); end
      checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
      checks++; if (rom_angle !== 7'd0) begin errors++; $display("FAIL reset_rom_angle got=%0d exp=0", rom_angle); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_cardinal();
      logic [6:0] a; logic z; int lat;
      run_request(16'd1000, 16'd0, a, z, lat);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL x_axis_angle got=%0d exp=0", a); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL x_axis_zero got=%b exp=0", z); end
      checks++; if (lat != 8) begin errors++; $display("FAIL x_axis_latency got=%0d exp=8", lat); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_handshake got=%b exp=1", in_ready); end
      run_request(16'd0, 16'd5, a, z, lat);
      checks++; if (a !== 7'd90) begin errors++; $display("FAIL y_axis_angle got=%0d exp=90", a); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL y_axis_zero got=%b exp=0", z); end
      run_request(16'd0, 16'd0, a, z, lat);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL zero_vec_angle got=%0d exp=0", a); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL zero_vec_flag got=%b exp=1", z); end
      checks++; if (lat != 1) begin errors++; $display("FAIL zero_vec_latency got=%0d exp=1", lat); end
   endtask

   task automatic test_interior();
      logic [W-1:0] xs [4] = '{16'd1000, 16'd10000, 16'd866, 16'd65535};
      logic [W-1:0] ys [4] = '{16'd1000, 16'd5774, 16'd500, 16'd65535};
      logic [6:0]   es [4] = '{7'd45, 7'd30, 7'd29, 7'd45};
      logic [6:0] a; logic z; int lat;
      for (int i = 0; i < 4; i++) begin
         run_request(xs[i], ys[i], a, z, lat);
         checks++;
         if (a !== es[i] || z !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL interior_%0d x=%0d y=%0d got angle=%0d zero=%b lat=%0d exp angle=%0d zero=0 lat=8",
                     i, xs[i], ys[i], a, z, lat, es[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] a; logic z; int lat;
      out_ready = 1'b0;
      run_request(16'd1000, 16'd1000, a, z, lat);
      checks++; if (a !== 7'd45 || lat != 8) begin errors++; $display("FAIL bp_result got=%0d lat=%0d exp=45 lat=8", a, lat); end
      in_valid = 1'b1; in_x = 16'd1; in_y = 16'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_angle !== 7'd45 || out_zero !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d got valid=%b angle=%0d zero=%b in_ready=%b exp 1/45/0/0",
                     i, out_valid, out_angle, out_zero, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_search();
      logic [6:0] a; logic z; int lat; int seen;
      in_x = 16'd1000; in_y = 16'd1000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rom_angle !== 7'd0) begin
         errors++;
         $display("FAIL midrst_idle got in_ready=%b valid=%b rom=%0d exp 1/0/0", in_ready, out_valid, rom_angle);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (out_valid) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
      run_request(16'd1000, 16'd1000, a, z, lat);
      checks++; if (a !== 7'd45 || lat != 8) begin errors++; $display("FAIL midrst_next got=%0d lat=%0d exp=45 lat=8", a, lat); end
   endtask

   task automatic test_back_to_back();
      int t0, t1, guard;
      in_x = 16'd1000; in_y = 16'd1000; in_valid = 1'b1;
      t0 = -1; t1 = -1; guard = 0;
      while (t1 < 0 && guard < 40) begin
         if (in_ready) begin if (t0 < 0) t0 = guard; else t1 = guard; end
         tick(); guard++;
      end
      in_valid = 1'b0;
      checks++; if (t1 - t0 != 9) begin errors++; $display("FAIL b2b_period got=%0d exp=9", t1 - t0); end
      guard = 0;
      while (!in_ready && guard < 20) begin tick(); guard++; end
   endtask

   task automatic test_sweep();
      logic [6:0] a; logic z; int lat; int bad;
      bad = 0;
      for (int k = 0; k <= 90; k++) begin
         run_request(cos_tab[k], sin_tab[k], a, z, lat);
         checks++;
         if (a !== 7'(k) || lat != 8) begin
            errors++; bad++;
            $display("FAIL sweep_%0d got=%0d lat=%0d exp=%0d lat=8", k, a, lat, k);
         end
      end
      checks++; if (rom_bad != 0) begin errors++; $display("FAIL rom_angle_range got=%0d exp=0", rom_bad); end
   endtask

   initial begin
      for (int k = 0; k <= 90; k++) begin
         sin_tab[k] = q15($sin(real'(k) * 3.14159265358979323846 / 180.0));
         cos_tab[k] = q15($cos(real'(k) * 3.14159265358979323846 / 180.0));
      end
      test_reset();
      test_cardinal();
      test_interior();
      test_backpressure();
      test_reset_mid_search();
      test_back_to_back();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
